// File: rtl/nmr_echo_acq_sched_if.sv
// Control/status bundle of the echo-train acquisition scheduler.
// The sequencer side drives the train request and pulse strobe; the scheduler
// side returns the acquisition window and progress flags.
interface nmr_echo_acq_sched_if #(
    parameter int CNT_W  = 16,
    parameter int ECHO_W = 11
);
    logic              start;
    logic              abort;
    logic [ECHO_W-1:0] echo_num;
    logic [CNT_W-1:0]  dead_len;
    logic [CNT_W-1:0]  acq_len;
    logic              pulse180_done;
    logic              acq_en;
    logic              echo_strb;
    logic [ECHO_W-1:0] echo_idx;
    logic              busy;
    logic              done;
    logic              overrun;

    modport master (
        output start, abort, echo_num, dead_len, acq_len, pulse180_done,
        input  acq_en, echo_strb, echo_idx, busy, done, overrun
    );

    modport slave (
        input  start, abort, echo_num, dead_len, acq_len, pulse180_done,
        output acq_en, echo_strb, echo_idx, busy, done, overrun
    );
endinterface

// File: rtl/nmr_echo_acq_sched.sv
// CPMG echo-train acquisition scheduler: after each 180-degree pulse strobe it
// waits dead_len cycles, opens acq_en for acq_len cycles, then counts the echo.
// Repeats until echo_num echoes are done. Single clock domain (dds).
module nmr_echo_acq_sched #(
    parameter int CNT_W  = 16,
    parameter int ECHO_W = 11
) (
    input  logic                  dds,
    input  logic                  rst_n,
    nmr_echo_acq_sched_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT180 = 3'd1,
        S_DEAD    = 3'd2,
        S_ACQ     = 3'd3,
        S_FIN     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  dead_len_q, dead_len_d;
    logic [CNT_W-1:0]  acq_len_q, acq_len_d;
    logic [ECHO_W-1:0] echo_num_q, echo_num_d;
    logic [ECHO_W-1:0] echo_idx_q, echo_idx_d;
    logic              acq_en_q, acq_en_d;
    logic              echo_strb_q, echo_strb_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [ECHO_W-1:0] echo_idx_inc;

    // echo_idx stays below echo_num while a train runs, so +1 cannot overflow.
    assign echo_idx_inc = echo_idx_q + ECHO_W'(1);

    // State and output registers; reset clears everything, including config.
    always_ff @(posedge dds or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dead_len_q  <= '0;
            acq_len_q   <= '0;
            echo_num_q  <= '0;
            echo_idx_q  <= '0;
            acq_en_q    <= 1'b0;
            echo_strb_q <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dead_len_q  <= dead_len_d;
            acq_len_q   <= acq_len_d;
            echo_num_q  <= echo_num_d;
            echo_idx_q  <= echo_idx_d;
            acq_en_q    <= acq_en_d;
            echo_strb_q <= echo_strb_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic; abort outranks every other transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dead_len_d  = dead_len_q;
        acq_len_d   = acq_len_q;
        echo_num_d  = echo_num_q;
        echo_idx_d  = echo_idx_q;
        acq_en_d    = 1'b0;
        echo_strb_d = 1'b0;
        done_d      = done_q;
        overrun_d   = overrun_q;

        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        overrun_d = 1'b0;
                        // A zero-length train completes without ever going busy.
                        done_d    = (bus.echo_num == '0);
                        if (bus.echo_num != '0) begin
                            echo_num_d = bus.echo_num;
                            dead_len_d = bus.dead_len;
                            acq_len_d  = bus.acq_len;
                            echo_idx_d = '0;
                            state_d    = S_WAIT180;
                        end
                    end
                end
                S_WAIT180: begin
                    if (bus.pulse180_done) begin
                        if (dead_len_q != '0) begin
                            cnt_d   = dead_len_q;
                            state_d = S_DEAD;
                        end else begin
                            cnt_d   = acq_len_q;
                            state_d = S_ACQ;
                        end
                    end
                end
                S_DEAD: begin
                    if (bus.pulse180_done) overrun_d = 1'b1;
                    // Entered with cnt >= 1; leave on the last dead cycle.
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = acq_len_q;
                        state_d = S_ACQ;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_ACQ: begin
                    if (bus.pulse180_done) overrun_d = 1'b1;
                    // acq_en is registered, so it trails the remaining count by a cycle.
                    if (cnt_q != '0) begin
                        acq_en_d = 1'b1;
                        cnt_d    = cnt_q - CNT_W'(1);
                    end else begin
                        echo_strb_d = 1'b1;
                        echo_idx_d  = echo_idx_inc;
                        state_d     = (echo_idx_inc == echo_num_q) ? S_FIN : S_WAIT180;
                    end
                end
                S_FIN: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.acq_en    = acq_en_q;
    assign bus.echo_strb = echo_strb_q;
    assign bus.echo_idx  = echo_idx_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_nmr_echo_acq_sched.sv
// Directed bench for nmr_echo_acq_sched: basic train, zero lengths, overrun,
// ignored/degenerate start, abort and asynchronous reset mid-train.
module tb_nmr_echo_acq_sched;
    logic dds;
    logic rst_n;
    int   checks;
    int   errors;

    nmr_echo_acq_sched_if #(.CNT_W(16), .ECHO_W(11)) bus ();

    nmr_echo_acq_sched #(.CNT_W(16), .ECHO_W(11)) dut (
        .dds   (dds),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial dds = 1'b0;
    always #5 dds = ~dds;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge dds);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_train(input int n, input int d, input int a);
        bus.echo_num = 11'(n);
        bus.dead_len = 16'(d);
        bus.acq_len  = 16'(a);
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    // One echo slot: strobe at edge k, then check acq_en/echo_strb per cycle.
    // xp>0 injects an extra pulse180_done sampled at edge k+xp.
    task automatic slot(input int d, input int a, input int idx_exp, input int xp);
        bus.pulse180_done = 1'b1;
        step();
        bus.pulse180_done = 1'b0;
        chk("acq_en_at_k", 32'(bus.acq_en), 32'd0);
        for (int j = 1; j <= d + a + 1; j++) begin
            bus.pulse180_done = (j == xp);
            step();
            bus.pulse180_done = 1'b0;
            chk($sformatf("acq_en_j%0d", j), 32'(bus.acq_en), 32'((j >= d + 1) && (j <= d + a)));
            chk($sformatf("echo_strb_j%0d", j), 32'(bus.echo_strb), 32'(j == d + a + 1));
        end
        chk("echo_idx", 32'(bus.echo_idx), 32'(idx_exp));
        chk("busy_strb", 32'(bus.busy), 32'd1);
    endtask

    task automatic chk_outs(input string tag, input int acq, input int strb, input int idx,
                            input int bsy, input int dn, input int ovr);
        chk({tag, "_acq_en"},    32'(bus.acq_en),    32'(acq));
        chk({tag, "_echo_strb"}, 32'(bus.echo_strb), 32'(strb));
        chk({tag, "_echo_idx"},  32'(bus.echo_idx),  32'(idx));
        chk({tag, "_busy"},      32'(bus.busy),      32'(bsy));
        chk({tag, "_done"},      32'(bus.done),      32'(dn));
        chk({tag, "_overrun"},   32'(bus.overrun),   32'(ovr));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n             = 1'b0;
        bus.start         = 1'b0;
        bus.abort         = 1'b0;
        bus.echo_num      = '0;
        bus.dead_len      = '0;
        bus.acq_len       = '0;
        bus.pulse180_done = 1'b0;
        #1;
        chk_outs("reset", 0, 0, 0, 0, 0, 0);
        #20 rst_n = 1'b1;
        step();
        chk_outs("idle", 0, 0, 0, 0, 0, 0);

        // Basic train: 3 echoes, dead 4, window 8, strobes 40 cycles apart.
        start_train(3, 4, 8);
        chk("basic_busy", 32'(bus.busy), 32'd1);
        chk("basic_done", 32'(bus.done), 32'd0);
        for (int e = 1; e <= 3; e++) begin
            slot(4, 8, e, 0);
            if (e < 3) repeat (26) step();
        end
        step();
        chk("basic_fin_done", 32'(bus.done), 32'd1);
        chk("basic_fin_busy", 32'(bus.busy), 32'd0);

        // Zero dead time, one-cycle window, then zero-length window.
        start_train(1, 0, 1);
        chk("z1_done_clr", 32'(bus.done), 32'd0);
        slot(0, 1, 1, 0);
        step();
        chk("z1_done", 32'(bus.done), 32'd1);
        start_train(1, 0, 0);
        slot(0, 0, 1, 0);
        step();
        chk("z0_done", 32'(bus.done), 32'd1);
        chk("z0_busy", 32'(bus.busy), 32'd0);

        // Overrun: extra strobe inside the first window.
        start_train(2, 2, 5);
        slot(2, 5, 1, 5);
        chk("ovr_set", 32'(bus.overrun), 32'd1);
        slot(2, 5, 2, 0);
        chk("ovr_sticky", 32'(bus.overrun), 32'd1);
        step();
        chk("ovr_done", 32'(bus.done), 32'd1);

        // New start clears overrun; a start while busy is ignored.
        start_train(1, 3, 2);
        chk("ovr_clr", 32'(bus.overrun), 32'd0);
        chk("ign_busy0", 32'(bus.busy), 32'd1);
        start_train(5, 0, 7);
        chk("ign_busy1", 32'(bus.busy), 32'd1);
        chk("ign_idx", 32'(bus.echo_idx), 32'd0);
        slot(3, 2, 1, 0);
        step();
        chk("ign_done", 32'(bus.done), 32'd1);
        chk("ign_fin_busy", 32'(bus.busy), 32'd0);

        // Abort inside the second window of a 5-echo train.
        start_train(5, 1, 4);
        slot(1, 4, 1, 0);
        bus.pulse180_done = 1'b1;
        step();
        bus.pulse180_done = 1'b0;
        repeat (3) step();
        chk("abort_pre_acq", 32'(bus.acq_en), 32'd1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk_outs("abort", 0, 0, 1, 0, 0, 0);

        // Zero-echo start: done next cycle, never busy, echo_idx held.
        start_train(0, 3, 3);
        chk_outs("zero_n", 0, 0, 1, 0, 1, 0);
        repeat (3) step();
        chk("zero_n_busy_later", 32'(bus.busy), 32'd0);

        // Normal run after abort.
        start_train(1, 0, 2);
        chk("rerun_busy", 32'(bus.busy), 32'd1);
        chk("rerun_idx", 32'(bus.echo_idx), 32'd0);
        chk("rerun_done", 32'(bus.done), 32'd0);
        slot(0, 2, 1, 0);
        step();
        chk("rerun_fin_done", 32'(bus.done), 32'd1);

        // Asynchronous reset inside DEAD of the second echo.
        start_train(2, 6, 3);
        slot(6, 3, 1, 0);
        bus.pulse180_done = 1'b1;
        step();
        bus.pulse180_done = 1'b1;
        step();
        bus.pulse180_done = 1'b0;
        chk("rst_pre_ovr", 32'(bus.overrun), 32'd1);
        chk("rst_pre_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        bus.pulse180_done = 1'b1;
        repeat (3) step();
        bus.pulse180_done = 1'b0;
        repeat (3) step();
        chk_outs("post_rst", 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
